// File: rtl/stack_cpu_pkg.sv
// stack_cpu_pkg: shared widths, phase/opcode encodings and ALU function codes for the stack CPU
package stack_cpu_pkg;
  localparam int INSN_W = 16;
  localparam int PC_W = 10;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, LOAD = 2'd2} phase_t;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_PUSH = 4'h1, OP_JMP = 4'h2, OP_JZ = 4'h3,
    OP_LD = 4'h4, OP_ST = 4'h5, OP_ALU = 4'h6
  } opcode_t;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOT = 4'd5;
  localparam logic [3:0] ALU_EQ = 4'd6;
  localparam logic [3:0] ALU_LTU = 4'd7;
  localparam logic [3:0] ALU_DUP = 4'd8;
  localparam logic [3:0] ALU_DROP = 4'd9;
endpackage

// File: rtl/stack_cpu_if.sv
// stack_cpu_if: CPU bus (master drives pc/mem_addr/wr_data/mem_wr, slave returns registered insn/rd_data)
interface stack_cpu_if;
  import stack_cpu_pkg::*;
  logic [PC_W-1:0] pc;
  logic [INSN_W-1:0] insn;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] wr_data;
  logic mem_wr;
  modport master(output pc, mem_addr, wr_data, mem_wr, input insn, rd_data);
  modport slave(input pc, mem_addr, wr_data, mem_wr, output insn, rd_data);
endinterface

// File: rtl/stack_cpu_alu.sv
// stack_cpu_alu: combinational 8-bit ALU; in a (next), b (TOS), func[3:0]; out y
module stack_cpu_alu
  import stack_cpu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        func,
  output logic [DATA_W-1:0] y
);
  always_comb
    y = func == ALU_ADD ? a + b :
        func == ALU_SUB ? a - b :
        func == ALU_AND ? a & b :
        func == ALU_OR  ? a | b :
        func == ALU_XOR ? a ^ b :
        func == ALU_EQ  ? DATA_W'(a == b) :
        func == ALU_LTU ? DATA_W'(a < b) :
        func == ALU_NOT ? ~b : b;
endmodule

// File: rtl/stack_cpu.sv
// stack_cpu: 8-bit stack-machine core; clk, rst (sync high), bus (pc/insn ROM side, mem_addr/rd_data/wr_data/mem_wr RAM side)
module stack_cpu
  import stack_cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  stack_cpu_if.master bus
);
  phase_t phase;
  logic [PC_W-1:0] pc;
  logic [DATA_W-1:0] stack [STACK_DEPTH];
  logic [DATA_W-1:0] nxt [STACK_DEPTH];
  logic [DATA_W-1:0] alu_y, top_val;
  opcode_t op;
  logic [3:0] func;
  logic exec, binary, sh_dn, sh_up, set_top, take, unused;
  assign op = opcode_t'(bus.insn[15:12]);
  assign func = bus.insn[3:0];
  assign exec = phase == EXEC;
  assign binary = func <= ALU_XOR || func == ALU_EQ || func == ALU_LTU;
  assign unused = ^bus.insn[11:10];
  stack_cpu_alu u_alu (.a(stack[1]), .b(stack[0]), .func(func), .y(alu_y));
  always_comb begin
    sh_dn = phase == LOAD || exec && (op == OP_PUSH || op == OP_ALU && func == ALU_DUP);
    sh_up = exec && (op == OP_JZ || op == OP_ST || op == OP_ALU && (binary || func == ALU_DROP));
    set_top = phase == LOAD || exec && (op == OP_PUSH || op == OP_ALU && (binary || func == ALU_NOT || func == ALU_DUP));
    top_val = phase == LOAD ? bus.rd_data : op == OP_PUSH ? bus.insn[7:0] : func == ALU_DUP ? stack[0] : alu_y;
    take = op == OP_JMP || op == OP_JZ && stack[0] == '0;
    nxt[0] = set_top ? top_val : sh_up ? stack[1] : stack[0];
    for (int i = 1; i < STACK_DEPTH - 1; i++)
      nxt[i] = sh_dn ? stack[i-1] : sh_up ? stack[i+1] : stack[i];
    nxt[STACK_DEPTH-1] = sh_dn ? stack[STACK_DEPTH-2] : sh_up ? '0 : stack[STACK_DEPTH-1];
  end
  always_ff @(posedge clk)
    if (rst) begin
      phase <= FETCH;
      pc <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= nxt[i];
      phase <= phase == FETCH ? EXEC : exec && op == OP_LD ? LOAD : FETCH;
      if (exec) pc <= take ? bus.insn[PC_W-1:0] : pc + PC_W'(1);
    end
  assign bus.pc = pc;
  assign bus.mem_addr = bus.insn[7:0];
  assign bus.wr_data = stack[0];
  assign bus.mem_wr = exec && op == OP_ST && !rst;
endmodule

// File: tb/tb_stack_cpu.sv
// tb_stack_cpu: table-driven programs plus hand sequences, checked per cycle against an ISA model
module tb_stack_cpu;
  import stack_cpu_pkg::*;
  localparam int D = 8;
  typedef struct {
    int base;
    int len;
    logic [7:0] out;
    int nwr;
    int first;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_clr = 1'b1;
  stack_cpu_if bus();
  stack_cpu #(.STACK_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [15:0] rom [1024];
  logic [7:0] ram [256];
  always @(posedge clk) begin
    bus.insn <= rom[bus.pc];
    bus.rd_data <= ram[bus.mem_addr];
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (bus.mem_wr) ram[bus.mem_addr] <= bus.wr_data;
  end
  int checks = 0;
  int errors = 0;
  int ncy = 0;
  int out_cnt = 0;
  int first = 0;
  logic [7:0] out_val;
  logic [1:0] m_phase;
  logic [9:0] m_pc;
  logic [7:0] m_stk [D];
  logic [7:0] m_ram [256];
  logic [7:0] m_ld;
  logic [15:0] img [$];
  vec_t vecs [$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", n, ncy, act, exp);
    end
  endtask
  task automatic m_push(input logic [7:0] v);
    for (int i = D - 1; i > 0; i--) m_stk[i] = m_stk[i-1];
    m_stk[0] = v;
  endtask
  task automatic m_pop(output logic [7:0] v);
    v = m_stk[0];
    for (int i = 0; i < D - 1; i++) m_stk[i] = m_stk[i+1];
    m_stk[D-1] = 8'h00;
  endtask
  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd6: return (a == b) ? 8'd1 : 8'd0;
      4'd7: return (a < b) ? 8'd1 : 8'd0;
      default: return 8'h00;
    endcase
  endfunction
  task automatic step();
    logic [15:0] w;
    logic [7:0] a, b;
    logic [9:0] npc;
    if (rst) begin
      m_phase = 2'd0;
      m_pc = 10'd0;
      for (int i = 0; i < D; i++) m_stk[i] = 8'h00;
    end else if (m_phase == 2'd0) m_phase = 2'd1;
    else if (m_phase == 2'd2) begin
      m_push(m_ram[m_ld]);
      m_phase = 2'd0;
    end else begin
      w = rom[m_pc];
      npc = m_pc + 10'd1;
      m_phase = 2'd0;
      case (w[15:12])
        4'h1: m_push(w[7:0]);
        4'h2: npc = w[9:0];
        4'h3: begin m_pop(a); if (a == 8'h00) npc = w[9:0]; end
        4'h4: begin m_ld = w[7:0]; m_phase = 2'd2; end
        4'h5: begin m_ram[w[7:0]] = m_stk[0]; m_pop(a); end
        4'h6:
          case (w[3:0])
            4'd5: m_stk[0] = ~m_stk[0];
            4'd8: m_push(m_stk[0]);
            4'd9: m_pop(a);
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7: begin
              m_pop(b);
              m_pop(a);
              m_push(ref_alu(a, b, w[3:0]));
            end
            default: ;
          endcase
        default: ;
      endcase
      m_pc = npc;
    end
  endtask
  task automatic check();
    logic exp_wr;
    exp_wr = m_phase == 2'd1 && rom[m_pc][15:12] == 4'h5 && !rst;
    chk("phase", dut.phase, m_phase);
    chk("pc", dut.pc, m_pc);
    chk("stack0", dut.stack[0], m_stk[0]);
    chk("stack1", dut.stack[1], m_stk[1]);
    chk("stack2", dut.stack[2], m_stk[2]);
    chk("stack3", dut.stack[3], m_stk[3]);
    chk("mem_wr", bus.mem_wr, exp_wr);
    if (exp_wr) begin
      chk("mem_addr", bus.mem_addr, rom[m_pc][7:0]);
      chk("wr_data", bus.wr_data, m_stk[0]);
    end
    if (bus.mem_wr === 1'b1 && bus.mem_addr == 8'h01) begin
      out_val = bus.wr_data;
      out_cnt++;
      if (out_cnt == 1) first = ncy;
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    step();
    @(negedge clk);
    ncy++;
    check();
  endtask
  task automatic setup(input int base, input int len);
    rst = 1'b1;
    ram_clr = 1'b1;
    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
    for (int i = 0; i < len; i++) rom[i] = img[base+i];
    for (int i = 0; i < 256; i++) m_ram[i] = 8'h00;
    cyc();
    cyc();
    rst = 1'b0;
    ram_clr = 1'b0;
    ncy = 1;
    out_cnt = 0;
    out_val = 8'h00;
    first = 0;
  endtask
  task automatic add(input int b, input logic [7:0] o, input int n, input int f);
    vecs.push_back('{b, img.size() - b, o, n, f});
  endtask
  initial begin
    int b;
    b = img.size(); img = {img, 16'h102A, 16'h5001}; add(b, 8'h2A, 1, 4);
    b = img.size(); img = {img, 16'h1003, 16'h1004, 16'h6000, 16'h5001}; add(b, 8'h07, 1, 8);
    b = img.size(); img = {img, 16'h1002, 16'h1005, 16'h6001, 16'h5001}; add(b, 8'hFD, 1, 8);
    b = img.size(); img = {img, 16'h1055, 16'h5010, 16'h4010, 16'h5001}; add(b, 8'h55, 1, 9);
    b = img.size(); img = {img, 16'h1000, 16'h3005, 16'h10EE, 16'h5001, 16'h0000, 16'h1009, 16'h5001}; add(b, 8'h09, 1, 8);
    b = img.size(); img = {img, 16'h1001, 16'h3006, 16'h1033, 16'h5001, 16'h2004}; add(b, 8'h33, 1, 8);
    b = img.size(); img = {img, 16'h10F0, 16'h103C, 16'h6002, 16'h6005, 16'h5001}; add(b, 8'hCF, 1, 10);
    b = img.size(); img = {img, 16'h1005, 16'h1005, 16'h6006, 16'h1080, 16'h6003, 16'h5001}; add(b, 8'h81, 1, 12);
    b = img.size();
    img = {img, 16'h1003, 16'h1009, 16'h6007, 16'h6008, 16'h6004, 16'h1007,
           16'h6009, 16'h1011, 16'h6000, 16'h600A, 16'hF123, 16'h5001};
    add(b, 8'h11, 1, 24);
    b = img.size();
    for (int i = 1; i <= D + 1; i++) img.push_back(16'h1000 | 16'(i));
    for (int i = 1; i <= D + 1; i++) img.push_back(16'h5001);
    add(b, 8'h00, D + 1, 2 * (D + 1) + 2);
    setup(vecs[0].base, vecs[0].len);
    chk("reset_phase", dut.phase, FETCH);
    chk("reset_pc", dut.pc, 10'd0);
    chk("reset_stack7", dut.stack[D-1], 8'h00);
    chk("reset_mem_wr", bus.mem_wr, 1'b0);
    foreach (vecs[v]) begin
      setup(vecs[v].base, vecs[v].len);
      repeat (60) cyc();
      chk($sformatf("vec%0d_out", v), out_val, vecs[v].out);
      chk($sformatf("vec%0d_nwr", v), out_cnt, vecs[v].nwr);
      chk($sformatf("vec%0d_first", v), first, vecs[v].first);
    end
    setup(vecs[0].base, vecs[0].len);
    repeat (3) cyc();
    chk("st_wr_before_rst", bus.mem_wr, 1'b1);
    rst = 1'b1;
    #1;
    chk("st_wr_during_rst", bus.mem_wr, 1'b0);
    cyc();
    chk("rst_no_write", ram[1], 8'h00);
    chk("rst_pc", dut.pc, 10'd0);
    chk("rst_phase", dut.phase, FETCH);
    chk("rst_stack0", dut.stack[0], 8'h00);
    chk("rst_stack7", dut.stack[D-1], 8'h00);
    rst = 1'b0;
    ncy = 1;
    repeat (6) cyc();
    chk("rerun_write", ram[1], 8'h2A);
    setup(0, 0);
    rom[0] = 16'h23FE;
    rom[10'h3FE] = 16'h105A;
    rom[10'h3FF] = 16'h5001;
    repeat (6) cyc();
    chk("wrap_pc", dut.pc, 10'd0);
    chk("wrap_write", ram[1], 8'h5A);
    chk("wrap_out", out_val, 8'h5A);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
